// File: rtl/draw_ball_ctl_if.sv
// VGA pixel stream bundle shared by the pong drawing stages.
// "in" is the receiving side of a stage, "out" the driving side.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in (
    input vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
  );

  modport out (
    output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
  );
endinterface

// File: rtl/draw_ball_ctl.sv
// Ball stage of the pong pipeline: owns ball position/direction, updates it
// once per frame (on the rising edge of vblnk), bounces off the field edges
// and rackets, overlays the ball on the stream and pulses the score outputs.
module draw_ball_ctl #(
  parameter int          BALL_SIZE      = 16,
  parameter int          SPEED          = 4,
  parameter int          FIELD_TOP      = 51,
  parameter int          FIELD_BOTTOM   = 717,
  parameter int          RACKET_H       = 80,
  parameter int          RACKET_W       = 8,
  parameter int          LEFT_RACKET_X  = 16,
  parameter int          RIGHT_RACKET_X = 1000,
  parameter int          SERVE_FRAMES   = 60,
  parameter logic [11:0] BALL_RGB       = 12'hF_F_0
) (
  input  logic        clk65MHz,
  input  logic        rst,
  input  logic [11:0] left_ypos,
  input  logic [11:0] right_ypos,
  input  logic        screen_idle,
  vga_if.in           draw_in_if,
  vga_if.out          draw_out_if,
  output logic        score_left,
  output logic        score_right
);

  typedef enum logic [1:0] {IDLE, SERVE, MOVE, SCORED} state_t;

  // Comparison constants are 12 bits wide so sums like x+size+speed never wrap.
  localparam logic [11:0] SZ       = 12'(BALL_SIZE);
  localparam logic [11:0] SPD      = 12'(SPEED);
  localparam logic [11:0] TOP      = 12'(FIELD_TOP);
  localparam logic [11:0] BOT      = 12'(FIELD_BOTTOM);
  localparam logic [11:0] RH       = 12'(RACKET_H);
  localparam logic [11:0] CLAMP_HI = 12'(FIELD_BOTTOM - RACKET_H);
  localparam logic [11:0] FACE_L   = 12'(LEFT_RACKET_X + RACKET_W);
  localparam logic [11:0] FACE_R   = 12'(RIGHT_RACKET_X);
  localparam logic [11:0] SCREEN_W = 12'd1024;
  // Position update constants in the 11-bit register width.
  localparam logic [10:0] SPD11    = 11'(SPEED);
  localparam logic [10:0] CX11     = 11'((1024 - BALL_SIZE) / 2);
  localparam logic [10:0] CY11     = 11'((FIELD_TOP + FIELD_BOTTOM - BALL_SIZE) / 2);
  localparam logic [10:0] TOP11    = 11'(FIELD_TOP);
  localparam logic [10:0] LOW11    = 11'(FIELD_BOTTOM - BALL_SIZE);
  localparam logic [10:0] FACE_L11 = 11'(LEFT_RACKET_X + RACKET_W);
  localparam logic [10:0] FACE_R11 = 11'(RIGHT_RACKET_X - BALL_SIZE);
  localparam logic [5:0]  SERVE_LAST = 6'(SERVE_FRAMES - 1);

  state_t      state_reg, state_next;
  logic [10:0] ball_x_reg, ball_x_next;
  logic [10:0] ball_y_reg, ball_y_next;
  logic        dx_reg, dx_next;
  logic        dy_reg, dy_next;
  logic [5:0]  serve_cnt_reg, serve_cnt_next;
  logic        vblnk_prev_reg;
  logic        score_left_reg, score_left_next;
  logic        score_right_reg, score_right_next;

  logic [11:0] bx, by, eff_l, eff_r, hc, vc;
  logic        frame_tick, ovl_l, ovl_r, hit_l, hit_r, exit_l, exit_r, pixel_on;

  function automatic logic [11:0] clamp_racket(input logic [11:0] y);
    if (y < TOP)           return TOP;
    else if (y > CLAMP_HI) return CLAMP_HI;
    else                   return y;
  endfunction

  assign frame_tick = draw_in_if.vblnk & ~vblnk_prev_reg;
  assign bx    = {1'b0, ball_x_reg};
  assign by    = {1'b0, ball_y_reg};
  assign eff_l = clamp_racket(left_ypos);
  assign eff_r = clamp_racket(right_ypos);
  assign ovl_l = (by + SZ > eff_l) && (by < eff_l + RH);
  assign ovl_r = (by + SZ > eff_r) && (by < eff_r + RH);
  // Racket contact: the ball face crosses the racket face during this step.
  assign hit_l  = !dx_reg && (bx >= FACE_L) && (bx < FACE_L + SPD) && ovl_l;
  assign hit_r  = dx_reg && (bx + SZ <= FACE_R) && (bx + SZ + SPD > FACE_R) && ovl_r;
  assign exit_l = !dx_reg && (bx < SPD);
  assign exit_r = dx_reg && (bx + SZ + SPD > SCREEN_W);

  assign hc = {1'b0, draw_in_if.hcount};
  assign vc = {1'b0, draw_in_if.vcount};
  assign pixel_on = ((state_reg == SERVE) || (state_reg == MOVE)) &&
                    (hc >= bx) && (hc < bx + SZ) && (vc >= by) && (vc < by + SZ);

  assign score_left  = score_left_reg;
  assign score_right = score_right_reg;

  // State register for the ball FSM and its datapath.
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      state_reg       <= IDLE;
      ball_x_reg      <= CX11;
      ball_y_reg      <= CY11;
      dx_reg          <= 1'b1;
      dy_reg          <= 1'b1;
      serve_cnt_reg   <= '0;
      vblnk_prev_reg  <= 1'b0;
      score_left_reg  <= 1'b0;
      score_right_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ball_x_reg      <= ball_x_next;
      ball_y_reg      <= ball_y_next;
      dx_reg          <= dx_next;
      dy_reg          <= dy_next;
      serve_cnt_reg   <= serve_cnt_next;
      vblnk_prev_reg  <= draw_in_if.vblnk;
      score_left_reg  <= score_left_next;
      score_right_reg <= score_right_next;
    end
  end

  // Next-state logic: idle override first, otherwise act only on frame_tick.
  always_comb begin
    state_next       = state_reg;
    ball_x_next      = ball_x_reg;
    ball_y_next      = ball_y_reg;
    dx_next          = dx_reg;
    dy_next          = dy_reg;
    serve_cnt_next   = serve_cnt_reg;
    score_left_next  = 1'b0;
    score_right_next = 1'b0;
    if (screen_idle) begin
      state_next  = IDLE;
      ball_x_next = CX11;
      ball_y_next = CY11;
    end else if (frame_tick) begin
      case (state_reg)
        IDLE: begin
          state_next     = SERVE;
          serve_cnt_next = '0;
        end
        SERVE: begin
          if (serve_cnt_reg == SERVE_LAST) begin
            state_next     = MOVE;
            serve_cnt_next = '0;
          end else begin
            serve_cnt_next = serve_cnt_reg + 6'd1;
          end
        end
        MOVE: begin
          // Vertical: wall bounce snaps onto the wall, otherwise step.
          if (!dy_reg) begin
            if (by < TOP + SPD) begin
              ball_y_next = TOP11;
              dy_next     = 1'b1;
            end else begin
              ball_y_next = ball_y_reg - SPD11;
            end
          end else begin
            if (by + SZ + SPD > BOT) begin
              ball_y_next = LOW11;
              dy_next     = 1'b0;
            end else begin
              ball_y_next = ball_y_reg + SPD11;
            end
          end
          // Horizontal: racket bounce, else exit/score, else step.
          if (hit_l) begin
            ball_x_next = FACE_L11;
            dx_next     = 1'b1;
          end else if (hit_r) begin
            ball_x_next = FACE_R11;
            dx_next     = 1'b0;
          end else if (exit_l || exit_r) begin
            state_next       = SCORED;
            ball_x_next      = CX11;
            ball_y_next      = CY11;
            dx_next          = exit_r;
            score_right_next = exit_l;
            score_left_next  = exit_r;
          end else if (dx_reg) begin
            ball_x_next = ball_x_reg + SPD11;
          end else begin
            ball_x_next = ball_x_reg - SPD11;
          end
        end
        SCORED: begin
          state_next     = SERVE;
          serve_cnt_next = '0;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // One-cycle pass-through of the stream with the ball overlaid on rgb.
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      draw_out_if.vcount <= '0;
      draw_out_if.vsync  <= 1'b0;
      draw_out_if.vblnk  <= 1'b0;
      draw_out_if.hcount <= '0;
      draw_out_if.hsync  <= 1'b0;
      draw_out_if.hblnk  <= 1'b0;
      draw_out_if.rgb    <= '0;
    end else begin
      draw_out_if.vcount <= draw_in_if.vcount;
      draw_out_if.vsync  <= draw_in_if.vsync;
      draw_out_if.vblnk  <= draw_in_if.vblnk;
      draw_out_if.hcount <= draw_in_if.hcount;
      draw_out_if.hsync  <= draw_in_if.hsync;
      draw_out_if.hblnk  <= draw_in_if.hblnk;
      draw_out_if.rgb    <= pixel_on ? BALL_RGB : draw_in_if.rgb;
    end
  end

endmodule

// File: tb/tb_draw_ball_ctl.sv
// Self-checking bench for draw_ball_ctl: frame-level game model, random
// racket positions, ball position inferred from probed output pixels.
module tb_draw_ball_ctl;
  localparam logic [11:0] BALL = 12'hFF0;
  localparam int CX = 504, CY = 376;
  localparam int M_IDLE = 0, M_SERVE = 1, M_MOVE = 2, M_SCORED = 3;

  logic        clk65MHz = 1'b0;
  logic        rst;
  logic [11:0] left_ypos, right_ypos;
  logic        screen_idle;
  logic        score_left, score_right;

  vga_if in_if();
  vga_if out_if();

  draw_ball_ctl dut (
    .clk65MHz   (clk65MHz),
    .rst        (rst),
    .left_ypos  (left_ypos),
    .right_ypos (right_ypos),
    .screen_idle(screen_idle),
    .draw_in_if (in_if),
    .draw_out_if(out_if),
    .score_left (score_left),
    .score_right(score_right)
  );

  always #5 clk65MHz = ~clk65MHz;

  int checks = 0;
  int failures = 0;

  // Game model: where the ball is, which way it goes, what the game is doing.
  int m_mode, m_x, m_y, m_serve_left, m_hits, m_scores;
  bit m_right, m_down, m_exp_sl, m_exp_sr;

  function automatic int clamp_y(input int y);
    if (y < 51) return 51;
    if (y > 637) return 637;
    return y;
  endfunction

  function automatic bit overlaps(input int by, input int ypos);
    int top;
    top = clamp_y(ypos);
    return (by + 16 > top) && (by < top + 80);
  endfunction

  function automatic bit ball_covers(input int h, input int v);
    if (m_mode != M_SERVE && m_mode != M_MOVE) return 1'b0;
    return (h >= m_x) && (h < m_x + 16) && (v >= m_y) && (v < m_y + 16);
  endfunction

  function automatic logic [11:0] rand_rgb();
    logic [11:0] c;
    c = 12'($urandom);
    if (c == BALL) c = 12'h0F0;
    return c;
  endfunction

  function automatic logic [37:0] pack_in();
    return {in_if.hcount, in_if.vcount, in_if.hsync, in_if.vsync, in_if.hblnk, in_if.vblnk, in_if.rgb};
  endfunction

  function automatic logic [37:0] pack_out();
    return {out_if.hcount, out_if.vcount, out_if.hsync, out_if.vsync, out_if.hblnk, out_if.vblnk, out_if.rgb};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_x = CX; m_y = CY; m_right = 1; m_down = 1;
  endtask

  // Advance the game by one frame, given the racket inputs present at the tick.
  task automatic model_tick(input bit idle_in);
    int old_y;
    m_exp_sl = 0; m_exp_sr = 0;
    if (idle_in) begin
      m_mode = M_IDLE; m_x = CX; m_y = CY;
      return;
    end
    case (m_mode)
      M_IDLE:   begin m_mode = M_SERVE; m_serve_left = 60; end
      M_SERVE:  begin m_serve_left--; if (m_serve_left == 0) m_mode = M_MOVE; end
      M_SCORED: begin m_mode = M_SERVE; m_serve_left = 60; end
      default: begin
        old_y = m_y;
        if (!m_down) begin
          if (m_y - 4 < 51) begin m_y = 51; m_down = 1; end else m_y -= 4;
        end else begin
          if (m_y + 20 > 717) begin m_y = 701; m_down = 0; end else m_y += 4;
        end
        if (!m_right) begin
          if (m_x >= 24 && m_x - 4 < 24 && overlaps(old_y, int'(left_ypos))) begin
            m_x = 24; m_right = 1; m_hits++;
          end else if (m_x < 4) begin
            m_exp_sr = 1; m_mode = M_SCORED; m_right = 0; m_x = CX; m_y = CY; m_scores++;
          end else m_x -= 4;
        end else begin
          if (m_x + 16 <= 1000 && m_x + 20 > 1000 && overlaps(old_y, int'(right_ypos))) begin
            m_x = 984; m_right = 0; m_hits++;
          end else if (m_x + 20 > 1024) begin
            m_exp_sl = 1; m_mode = M_SCORED; m_right = 1; m_x = CX; m_y = CY; m_scores++;
          end else m_x += 4;
        end
      end
    endcase
  endtask

  task automatic probe(input int hc, input int vc);
    logic [10:0] h, v;
    logic [11:0] c, exp;
    h = 11'(hc); v = 11'(vc); c = rand_rgb();
    in_if.hcount = h; in_if.vcount = v; in_if.rgb = c;
    @(posedge clk65MHz); #1;
    exp = ball_covers(int'(h), int'(v)) ? BALL : c;
    checks++;
    if (out_if.rgb !== exp) begin
      failures++;
      $display("FAIL pixel(%0d,%0d): rgb=%h expected %h (model x=%0d y=%0d mode=%0d)",
               h, v, out_if.rgb, exp, m_x, m_y, m_mode);
    end
  endtask

  task automatic probe_ball(input int x, input int y);
    probe(x, y);
    probe(x + 15, y + 15);
    probe(x - 1, y);
    probe(x, y - 1);
    probe(x + 16, y + 15);
    probe(x + 15, y + 16);
    probe(x - 8 + $urandom_range(0, 31), y - 8 + $urandom_range(0, 31));
  endtask

  task automatic check_scores(input bit sl, input bit sr, input string tag);
    checks += 2;
    if (score_left !== sl) begin
      failures++;
      $display("FAIL %s score_left: got %b expected %b", tag, score_left, sl);
    end
    if (score_right !== sr) begin
      failures++;
      $display("FAIL %s score_right: got %b expected %b", tag, score_right, sr);
    end
  endtask

  // One frame: vblnk rises, score pulses checked, ball probed, vblnk falls.
  task automatic do_tick(input bit idle_in);
    in_if.vblnk = 1'b1;
    screen_idle = idle_in;
    model_tick(idle_in);
    @(posedge clk65MHz); #1;
    screen_idle = 1'b0;
    check_scores(m_exp_sl, m_exp_sr, "tick");
    @(posedge clk65MHz); #1;
    check_scores(1'b0, 1'b0, "after_tick");
    probe_ball(m_x, m_y);
    in_if.vblnk = 1'b0;
    @(posedge clk65MHz); #1;
  endtask

  function automatic logic [11:0] track_ypos();
    int v;
    v = m_y - 84 + int'($urandom_range(0, 104));
    if (v < 0) v = 0;
    return 12'(v);
  endfunction

  task automatic random_rackets();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 6) begin
      left_ypos = track_ypos(); right_ypos = track_ypos();
    end else if (sel < 8) begin
      left_ypos = 12'($urandom); right_ypos = 12'($urandom);
    end else begin
      left_ypos = (sel == 8) ? 12'd10 : 12'd900;
      right_ypos = (sel == 8) ? 12'd900 : 12'd4095;
    end
  endtask

  task automatic randomize_stream(input bit vb);
    in_if.hcount = 11'($urandom); in_if.vcount = 11'($urandom);
    in_if.hsync = 1'($urandom); in_if.vsync = 1'($urandom);
    in_if.hblnk = 1'($urandom); in_if.vblnk = vb; in_if.rgb = rand_rgb();
  endtask

  task automatic test_reset();
    rst = 1'b1; screen_idle = 1'b0;
    randomize_stream(1'b1);
    @(posedge clk65MHz); #1;
    checks++;
    if (pack_out() !== 38'd0) begin
      failures++;
      $display("FAIL reset_stream: got %h expected 0", pack_out());
    end
    check_scores(1'b0, 1'b0, "reset");
    in_if.vblnk = 1'b0;
    @(posedge clk65MHz); #1;
    rst = 1'b0;
    model_reset();
    probe_ball(CX, CY);
  endtask

  task automatic test_passthrough();
    logic [37:0] exp;
    screen_idle = 1'b1;
    for (int i = 0; i < 40; i++) begin
      randomize_stream(1'($urandom));
      exp = pack_in();
      @(posedge clk65MHz); #1;
      checks++;
      if (pack_out() !== exp) begin
        failures++;
        $display("FAIL passthrough[%0d]: got %h expected %h", i, pack_out(), exp);
      end
    end
    in_if.vblnk = 1'b0; screen_idle = 1'b0;
    @(posedge clk65MHz); #1;
  endtask

  task automatic test_serve();
    left_ypos = 12'd340; right_ypos = 12'd340;
    for (int i = 0; i < 62; i++) do_tick(1'b0);
  endtask

  task automatic test_rally();
    for (int i = 0; i < 2200; i++) begin
      random_rackets();
      do_tick(1'b0);
    end
    $display("rally: racket hits=%0d scores=%0d", m_hits, m_scores);
  endtask

  task automatic reach_move();
    for (int i = 0; i < 200 && m_mode != M_MOVE; i++) do_tick(1'b0);
    checks++;
    if (m_mode != M_MOVE) begin
      failures++;
      $display("FAIL reach_move: mode=%0d expected %0d", m_mode, M_MOVE);
    end
  endtask

  task automatic test_idle_pulse();
    int ox, oy;
    reach_move();
    for (int i = 0; i < 5; i++) do_tick(1'b0);
    ox = m_x; oy = m_y;
    screen_idle = 1'b1;
    model_tick(1'b1);
    @(posedge clk65MHz); #1;
    screen_idle = 1'b0;
    check_scores(1'b0, 1'b0, "idle_pulse");
    probe_ball(ox, oy);
    probe_ball(CX, CY);
    for (int i = 0; i < 3; i++) do_tick(1'b0);
  endtask

  task automatic test_idle_on_exit();
    reach_move();
    for (int i = 0; i < 400; i++) begin
      if (m_mode == M_MOVE && ((!m_right && m_x < 4) || (m_right && m_x + 20 > 1024))) break;
      left_ypos = (m_y < 300) ? 12'd900 : 12'd0;
      right_ypos = left_ypos;
      do_tick(1'b0);
    end
    do_tick(1'b1);
    do_tick(1'b0);
  endtask

  task automatic test_mid_reset();
    logic [37:0] exp;
    reach_move();
    in_if.vblnk = 1'b0;
    @(posedge clk65MHz); #1;
    rst = 1'b1;
    randomize_stream(1'($urandom));
    @(posedge clk65MHz); #1;
    checks++;
    if (pack_out() !== 38'd0) begin
      failures++;
      $display("FAIL mid_reset_stream: got %h expected 0", pack_out());
    end
    check_scores(1'b0, 1'b0, "mid_reset");
    rst = 1'b0;
    model_reset();
    randomize_stream(1'b0);
    exp = pack_in();
    @(posedge clk65MHz); #1;
    checks++;
    if (pack_out() !== exp) begin
      failures++;
      $display("FAIL resume_stream: got %h expected %h", pack_out(), exp);
    end
    for (int i = 0; i < 3; i++) do_tick(1'b0);
  endtask

  initial begin
    rst = 1'b1; screen_idle = 1'b0;
    left_ypos = 12'd340; right_ypos = 12'd340;
    in_if.hcount = '0; in_if.vcount = '0; in_if.hsync = 1'b0; in_if.vsync = 1'b0;
    in_if.hblnk = 1'b0; in_if.vblnk = 1'b0; in_if.rgb = '0;
    m_hits = 0; m_scores = 0;
    model_reset();
    repeat (2) @(posedge clk65MHz);
    #1;
    test_reset();
    test_passthrough();
    test_serve();
    test_rally();
    test_idle_pulse();
    test_idle_on_exit();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
